// File: rtl/seg7_pkg.sv
// Decode constants and helpers shared by the 7-segment scan decoder.
// Segment codes are active-high, bit order gfedcba (bit 0 = segment a).
// seg_to_nibble returns {valid, nibble}; valid=0 for any pattern not in the table.
package seg7_pkg;

    localparam int N_DIG = 4;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    function automatic logic [4:0] seg_to_nibble(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            SEG_0:   r = 5'h10;
            SEG_1:   r = 5'h11;
            SEG_2:   r = 5'h12;
            SEG_3:   r = 5'h13;
            SEG_4:   r = 5'h14;
            SEG_5:   r = 5'h15;
            SEG_6:   r = 5'h16;
            SEG_7:   r = 5'h17;
            SEG_8:   r = 5'h18;
            SEG_9:   r = 5'h19;
            SEG_A:   r = 5'h1A;
            SEG_B:   r = 5'h1B;
            SEG_C:   r = 5'h1C;
            SEG_D:   r = 5'h1D;
            SEG_E:   r = 5'h1E;
            SEG_F:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_sync_stable.sv
// Synchroniser + stability filter for the HEX/DIG scan bus.
// Latency: 2 sync stages, then accept_o fires once a sample has held STABLE_CYC cycles.
// Ports: clk_i, rst_n_i (sync, active-low), hex_i/dig_i raw pins;
//        seg_o/dig_o normalised (lit/enabled = 1) stable sample, accept_o 1-cycle strobe.
module seg7_sync_stable
    import seg7_pkg::*;
#(
    parameter logic [24:0] STABLE_CYC     = 25'd4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [6:0]       hex_i,
    input  logic [N_DIG-1:0] dig_i,
    output logic [6:0]       seg_o,
    output logic [N_DIG-1:0] dig_o,
    output logic             accept_o
);

    localparam logic [6:0]       HEX_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [N_DIG-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

    logic [6:0]         hex_s1_q, hex_s2_q;
    logic [N_DIG-1:0]   dig_s1_q, dig_s2_q;
    logic [6+N_DIG:0]   samp_q, samp_d;
    logic [24:0]        cnt_q, cnt_d;
    logic               taken_q, taken_d;

    logic [6:0]         seg_n;
    logic [N_DIG-1:0]   dig_n;
    logic               changed;
    logic               accept;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hex_s1_q <= HEX_IDLE;
            hex_s2_q <= HEX_IDLE;
            dig_s1_q <= DIG_IDLE;
            dig_s2_q <= DIG_IDLE;
            samp_q   <= '0;
            cnt_q    <= '0;
            taken_q  <= 1'b0;
        end else begin
            hex_s1_q <= hex_i;
            hex_s2_q <= hex_s1_q;
            dig_s1_q <= dig_i;
            dig_s2_q <= dig_s1_q;
            samp_q   <= samp_d;
            cnt_q    <= cnt_d;
            taken_q  <= taken_d;
        end
    end

    always_comb begin
        seg_n   = SEG_ACTIVE_LOW ? ~hex_s2_q : hex_s2_q;
        dig_n   = DIG_ACTIVE_LOW ? ~dig_s2_q : dig_s2_q;
        samp_d  = {seg_n, dig_n};
        changed = (samp_d != samp_q);
        // A changing sample can never be accepted, even if the old one was about to qualify.
        accept  = !changed && !taken_q && (cnt_q == STABLE_CYC - 25'd1);
        if (changed) begin
            cnt_d   = '0;
            taken_d = 1'b0;
        end else begin
            cnt_d   = (cnt_q < STABLE_CYC) ? cnt_q + 25'd1 : cnt_q;
            taken_d = taken_q | accept;
        end
    end

    assign seg_o    = samp_q[6+N_DIG:N_DIG];
    assign dig_o    = samp_q[N_DIG-1:0];
    assign accept_o = accept;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed 4-digit 7-segment scan bus back into a 16-bit value per frame.
// Latency: 2 (sync) + STABLE_CYC + 1 cycles from final stable digit on pins to VALID.
// Ports: CLK, RST (sync active-low), HEX/DIG pins in; VALUE, VALID pulse, ERR pulse out;
//        ERR_CNT (saturating error count) only when SEG7_DEC_ERRCNT_EN is defined.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter logic [24:0] STABLE_CYC     = 25'd4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       HEX,
    input  logic [N_DIG-1:0] DIG,
    output logic [15:0]      VALUE,
    output logic             VALID,
    output logic             ERR
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    output logic [7:0]       ERR_CNT
`endif
);

    logic [6:0]       seg;
    logic [N_DIG-1:0] dig;
    logic             accept;

    seg7_sync_stable #(
        .STABLE_CYC     (STABLE_CYC),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
        .DIG_ACTIVE_LOW (DIG_ACTIVE_LOW)
    ) u_sync_stable (
        .clk_i    (CLK),
        .rst_n_i  (RST),
        .hex_i    (HEX),
        .dig_i    (DIG),
        .seg_o    (seg),
        .dig_o    (dig),
        .accept_o (accept)
    );

    logic [15:0]      shadow_q, shadow_d;
    logic [N_DIG-1:0] seen_q, seen_d;
    logic [15:0]      value_q, value_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [4:0]       dec;
    logic             dig_onehot;
    logic             good;
    logic [N_DIG-1:0] seen_new;

    always_comb begin
        dec        = seg_to_nibble(seg);
        dig_onehot = (dig != '0) && ((dig & (dig - 1'b1)) == '0);
        good       = accept && dig_onehot && dec[4];
        // Blanking (no digit enabled) is part of a normal scan and is silently ignored.
        err_d      = accept && (dig != '0) && !(dig_onehot && dec[4]);
        seen_new   = seen_q | dig;

        shadow_d = shadow_q;
        seen_d   = seen_q;
        value_d  = value_q;
        valid_d  = 1'b0;

        if (good) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (dig[i]) begin
                    shadow_d[4*i +: 4] = dec[3:0];
                end
            end
            if (seen_new == {N_DIG{1'b1}}) begin
                value_d = shadow_d;
                valid_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_new;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            shadow_q <= '0;
            seen_q   <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign VALUE = value_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (err_d && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign ERR_CNT = errcnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scans, glitches, errors, mid-frame reset,
// then randomized scan segments checked against a digit-level reference model.
module tb_seg7_scan_decoder;

    localparam logic [24:0] STB      = 25'd4;
    localparam int          MIN_HOLD = int'(STB) + 1;  // pin cycles a sample must hold to be taken

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  HEX;
    logic [3:0]  DIG;
    logic [15:0] VALUE;
    logic        VALID;
    logic        ERR;
`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0]  ERR_CNT;
`endif

    always #5 CLK = ~CLK;

    seg7_scan_decoder #(
        .STABLE_CYC     (STB),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .HEX     (HEX),
        .DIG     (DIG),
        .VALUE   (VALUE),
        .VALID   (VALID),
        .ERR     (ERR)
`ifdef SEG7_DEC_ERRCNT_EN
        ,
        .ERR_CNT (ERR_CNT)
`endif
    );

    typedef struct {
        bit          is_err;
        logic [15:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [6:0]  tab [16];
    int          m_shadow [4];
    bit          m_seen   [4];
    int          n_valid_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: one accepted sample, active-high segment/digit values.
    task automatic model_accept(input logic [6:0] seg, input logic [3:0] dig);
        exp_t e;
        int   nib;
        int   k;
        bit   all;
        if (dig == 4'b0) return;
        if ($countones(dig) != 1) begin
            e.is_err = 1'b1; e.val = '0; exp_q.push_back(e);
            return;
        end
        nib = -1;
        for (int i = 0; i < 16; i++) if (tab[i] == seg) nib = i;
        if (nib < 0) begin
            e.is_err = 1'b1; e.val = '0; exp_q.push_back(e);
            return;
        end
        k = 0;
        for (int i = 0; i < 4; i++) if (dig[i]) k = i;
        m_shadow[k] = nib;
        m_seen[k]   = 1'b1;
        all = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
        if (all) begin
            e.is_err = 1'b0;
            e.val = 16'(m_shadow[3] * 4096 + m_shadow[2] * 256 + m_shadow[1] * 16 + m_shadow[0]);
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
        end
    endtask

    // Drive one pin state (given active-high) for 'hold' clock edges.
    task automatic drive(input logic [6:0] seg, input logic [3:0] dig, input int hold);
        HEX = ~seg;
        DIG = ~dig;
        if (hold >= MIN_HOLD) model_accept(seg, dig);
        repeat (hold) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(7'h00, 4'b0000, 12);   // let any in-flight output drain first
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; m_seen[i] = 1'b0; end
        check("reset_value", 32'(VALUE), 32'h0);
        check("reset_valid", 32'(VALID), 32'h0);
        check("reset_err",   32'(ERR),   32'h0);
        RST = 1'b1;
    endtask

    // Monitor: pop one expectation for every output pulse.
    always @(negedge CLK) begin
        if (RST === 1'b1 && (VALID || ERR)) begin
            exp_t e;
            check("valid_err_exclusive", 32'(VALID & ERR), 32'h0);
            if (VALID) n_valid_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: VALID=%b ERR=%b VALUE=%h, expected none", VALID, ERR, VALUE);
            end else begin
                e = exp_q.pop_front();
                check("out_kind_err", 32'(ERR), 32'(e.is_err));
                if (!e.is_err) check("out_value", 32'(VALUE), 32'(e.val));
            end
        end
    end

    initial begin
        int v0;
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; m_seen[i] = 1'b0; end
        HEX = 7'h7F;
        DIG = 4'hF;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("init_value", 32'(VALUE), 32'h0);
        check("init_valid", 32'(VALID), 32'h0);
        check("init_err",   32'(ERR),   32'h0);
        RST = 1'b1;

        // 1: clean scan 1,2,3,4 with exact latency check on the last digit.
        v0 = n_valid_seen;
        drive(tab[1], 4'b0001, 8);
        drive(tab[2], 4'b0010, 8);
        drive(tab[3], 4'b0100, 8);
        HEX = ~tab[4];
        DIG = ~4'b1000;
        model_accept(tab[4], 4'b1000);
        repeat (2 + int'(STB)) @(posedge CLK);
        #1;
        check("latency_before", 32'(VALID), 32'h0);
        @(posedge CLK);
        #1;
        check("latency_at",     32'(VALID), 32'h1);
        check("frame1_value",   32'(VALUE), 32'h4321);
        drive(tab[4], 4'b1000, 4);
        drive(7'h00, 4'b0000, 10);
        check("frame1_pulses",  32'(n_valid_seen - v0), 32'h1);

        // 2: one-cycle glitch (pins HEX=00 -> all segments lit) inside digit 2.
        drive(tab[1], 4'b0001, 8);
        drive(tab[2], 4'b0010, 8);
        drive(tab[3], 4'b0100, 5);
        drive(7'h7F,  4'b0100, 1);
        drive(tab[3], 4'b0100, 8);
        drive(tab[4], 4'b1000, 8);
        drive(7'h00, 4'b0000, 10);
        check("glitch_value", 32'(VALUE), 32'h4321);

        // 3: two digits enabled -> error, then 4: invalid pattern on digit 1.
        drive(tab[5], 4'b0011, 8);
        drive(tab[6], 4'b0001, 8);
        drive(7'h01,  4'b0010, 8);
        drive(tab[7], 4'b0100, 8);
        drive(tab[8], 4'b1000, 8);
        drive(7'h00,  4'b0000, 10);
        check("err_no_publish", 32'(VALUE), 32'h4321);
        drive(tab[9], 4'b0010, 8);
        drive(7'h00,  4'b0000, 10);
        check("frame_after_fix", 32'(VALUE), 32'h8796);

        // 5: reset after two digits captured, then a fresh A,b,C,d frame.
        drive(tab[1], 4'b0001, 8);
        drive(tab[2], 4'b0010, 8);
        do_reset();
        drive(tab[10], 4'b0001, 8);
        drive(tab[11], 4'b0010, 8);
        drive(tab[12], 4'b0100, 8);
        drive(tab[13], 4'b1000, 8);
        drive(7'h00,  4'b0000, 10);
        check("post_reset_value", 32'(VALUE), 32'hDCBA);

`ifdef SEG7_DEC_ERRCNT_EN
        // 6: error counter saturation and reset clear.
        for (int i = 0; i < 300; i++) begin
            drive(7'h01, 4'b0001, MIN_HOLD);
            drive(7'h00, 4'b0000, 1);
        end
        drive(7'h00, 4'b0000, 10);
        check("errcnt_sat", 32'(ERR_CNT), 32'hFF);
        do_reset();
        check("errcnt_clr", 32'(ERR_CNT), 32'h0);
`endif

        // Randomized scan segments.
        for (int n = 0; n < 300; n++) begin
            int          r;
            int          hold;
            logic [6:0]  s;
            logic [3:0]  d;
            r    = $urandom_range(0, 9);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MIN_HOLD - 1)
                                               : $urandom_range(MIN_HOLD, MIN_HOLD + 5);
            s = tab[$urandom_range(0, 15)];
            d = 4'(1 << $urandom_range(0, 3));
            if (r == 7) begin
                d = 4'($urandom_range(3, 15));
                if ($countones(d) == 1) d = 4'b1111;
            end else if (r == 8) begin
                s = 7'($urandom_range(0, 127));
            end else if (r == 9) begin
                d = 4'b0000;
            end
            drive(s, d, hold);
            drive(7'($urandom_range(0, 127)), 4'b0000, $urandom_range(1, 3));
            if (n == 150) do_reset();
        end

        drive(7'h00, 4'b0000, 2);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLK);
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
